// File: rtl/round_countdown_timer.sv
// round_countdown_timer
//   Per-round countdown for the Mental Math Binary Game. Counts the round time
//   down in BCD, one step per tick_1s pulse, gates the upstream one-second
//   timer through timer_enable, flags the final seconds and signals timeout.
//
// Parameters
//   START_SECONDS  round length in seconds (1..99)
//   WARN_SECONDS   warn is high while 1 <= remaining <= WARN_SECONDS (0..START_SECONDS)
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-low reset
//   start         in   pulse: load START_SECONDS and run (also restarts)
//   stop          in   pulse: freeze the count (player answered)
//   pause         in   level: hold the count while high
//   tick_1s       in   pulse from the one-second timer
//   timer_enable  out  high while the next state is RUNNING
//   secs_tens     out  BCD tens digit of remaining seconds
//   secs_ones     out  BCD ones digit of remaining seconds
//   running       out  high in RUNNING or PAUSED
//   warn          out  low-time indicator
//   time_up       out  one-cycle pulse when the count reaches 00
//   expired       out  high in EXPIRED until start or reset
//   state_dbg     out  current FSM state, for observation only
//
// Handshake: start, stop and tick_1s are single-cycle strobes acted on at the
// rising edge where they are sampled high; there is no back-pressure, so an
// input that is not accepted in the current state is simply dropped.
module round_countdown_timer #(
  parameter int START_SECONDS = 30,
  parameter int WARN_SECONDS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       tick_1s,
  output logic       timer_enable,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       warn,
  output logic       time_up,
  output logic       expired,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUNNING = 3'd1;
  localparam logic [2:0] S_PAUSED  = 3'd2;
  localparam logic [2:0] S_HALTED  = 3'd3;
  localparam logic [2:0] S_EXPIRED = 3'd4;

  localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);
  localparam logic [6:0] WARN_LIM   = 7'(WARN_SECONDS);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [3:0] tens_nx;
  logic [3:0] ones_nx;
  logic       terminal;
  logic [6:0] count_nx;
  logic       active_nx;
  logic       warn_nx;

  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    tens_nx  = secs_tens;
    ones_nx  = secs_ones;
    terminal = 1'b0;
    case (state)
      S_RUNNING: begin
        if (start) begin
          tens_nx = START_TENS;
          ones_nx = START_ONES;
        end else if (stop) begin
          state_nx = S_HALTED;
        end else if (pause) begin
          // A tick coincident with entering pause is intentionally dropped.
          state_nx = S_PAUSED;
        end else if (tick_1s) begin
          if (secs_ones != 4'd0) begin
            ones_nx = secs_ones - 4'd1;
          end else begin
            ones_nx = 4'd9;
            tens_nx = secs_tens - 4'd1;
          end
          if (secs_tens == 4'd0 && secs_ones == 4'd1) begin
            state_nx = S_EXPIRED;
            terminal = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (start) begin
          state_nx = S_RUNNING;
          tens_nx  = START_TENS;
          ones_nx  = START_ONES;
        end else if (stop) begin
          state_nx = S_HALTED;
        end else if (!pause) begin
          state_nx = S_RUNNING;
        end
      end
      S_IDLE, S_HALTED, S_EXPIRED: begin
        if (start) begin
          state_nx = S_RUNNING;
          tens_nx  = START_TENS;
          ones_nx  = START_ONES;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // warn is derived from the next-state count so it lines up with the digits.
  assign count_nx  = ({3'd0, tens_nx} * 7'd10) + {3'd0, ones_nx};
  assign active_nx = (state_nx == S_RUNNING) || (state_nx == S_PAUSED);
  assign warn_nx   = active_nx && (count_nx != 7'd0) && (count_nx <= WARN_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      secs_tens    <= START_TENS;
      secs_ones    <= START_ONES;
      timer_enable <= 1'b0;
      running      <= 1'b0;
      warn         <= 1'b0;
      time_up      <= 1'b0;
      expired      <= 1'b0;
    end else begin
      state        <= state_nx;
      secs_tens    <= tens_nx;
      secs_ones    <= ones_nx;
      timer_enable <= (state_nx == S_RUNNING);
      running      <= active_nx;
      warn         <= warn_nx;
      time_up      <= terminal;
      expired      <= (state_nx == S_EXPIRED);
    end
  end

endmodule

// File: tb/tb_round_countdown_timer.sv
// tb_round_countdown_timer
//   Directed round scenarios followed by randomized input traffic, every cycle
//   compared against an integer-seconds model of the round.
module tb_round_countdown_timer;

  localparam int START_S = 30;
  localparam int WARN_S  = 5;

  // Model modes
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAU  = 2;
  localparam int M_HALT = 3;
  localparam int M_EXP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       tick_1s = 1'b0;
  logic       timer_enable;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       running;
  logic       warn;
  logic       time_up;
  logic       expired;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int tu_seen  = 0;

  // Reference model: remaining seconds as a plain integer.
  int m_mode = M_IDLE;
  int m_rem  = START_S;
  int m_tu   = 0;

  round_countdown_timer #(.START_SECONDS(START_S), .WARN_SECONDS(WARN_S)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .tick_1s(tick_1s), .timer_enable(timer_enable), .secs_tens(secs_tens),
    .secs_ones(secs_ones), .running(running), .warn(warn), .time_up(time_up),
    .expired(expired), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge();
    m_tu = 0;
    if (!rst) begin
      m_mode = M_IDLE;
      m_rem  = START_S;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (start) m_rem = START_S;
          else if (stop) m_mode = M_HALT;
          else if (pause) m_mode = M_PAU;
          else if (tick_1s) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
              m_mode = M_EXP;
              m_tu   = 1;
            end
          end
        end
        M_PAU: begin
          if (start) begin
            m_rem  = START_S;
            m_mode = M_RUN;
          end else if (stop) m_mode = M_HALT;
          else if (!pause) m_mode = M_RUN;
        end
        default: begin
          if (start) begin
            m_rem  = START_S;
            m_mode = M_RUN;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    logic act;
    act = (m_mode == M_RUN) || (m_mode == M_PAU);
    chk("secs_tens",    {4'd0, secs_tens},   8'(m_rem / 10));
    chk("secs_ones",    {4'd0, secs_ones},   8'(m_rem % 10));
    chk("running",      {7'd0, running},     {7'd0, act});
    chk("warn",         {7'd0, warn},        {7'd0, act && m_rem >= 1 && m_rem <= WARN_S});
    chk("time_up",      {7'd0, time_up},     8'(m_tu));
    chk("expired",      {7'd0, expired},     {7'd0, m_mode == M_EXP});
    chk("timer_enable", {7'd0, timer_enable},{7'd0, m_mode == M_RUN});
    if (time_up === 1'b1) tu_seen++;
  endtask

  // driver: apply inputs for one edge, then compare after the edge
  task automatic step(input logic r, input logic s, input logic sp,
                      input logic p, input logic t);
    @(negedge clk);
    rst = r; start = s; stop = sp; pause = p; tick_1s = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 1);
      if ((i % 3) == 1) step(1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    // full round: start with coincident tick ignored, then 30 ticks
    step(1, 1, 0, 0, 1);
    tu_seen = 0;
    ticks(30);
    chk("single_time_up", 8'(tu_seen), 8'd1);
    step(1, 0, 0, 0, 1);   // ticks after expiry are ignored

    // pause scenario: restart, run down to 12
    step(1, 1, 0, 0, 0);
    ticks(18);
    step(1, 0, 0, 1, 1);   // pause with coincident tick
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);   // release pause
    step(1, 0, 0, 0, 1);   // -> 11
    chk("after_pause", {secs_tens, secs_ones}, 8'h11);

    // stop versus tick at 07
    ticks(4);
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("halted_07", {secs_tens, secs_ones}, 8'h07);

    // restart from RUNNING at 15
    step(1, 1, 0, 0, 0);
    ticks(15);
    step(1, 1, 0, 0, 0);
    // expire then restart
    tu_seen = 0;
    ticks(30);
    chk("second_time_up", 8'(tu_seen), 8'd1);
    step(1, 1, 0, 0, 0);
    // reset mid-round at 03
    ticks(27);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic r, s, sp, p, t;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 59) == 0);
      sp = ($urandom_range(0, 79) == 0);
      p  = ($urandom_range(0, 9) < 2) ? pause : ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 2) != 0);
      step(r, s, sp, p, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_countdown_timer.md
# round_countdown_timer

Per-round countdown for the Mental Math Binary Game. Sits directly downstream of the one-second timer chain: it gates that chain through `timer_enable`, consumes its one-cycle `tick_1s` pulse, and counts the round time down in BCD for the seven-segment display. It flags the final seconds and signals timeout to the game controller.

## Interface
Parameters:
- `START_SECONDS`, default 30: round length in seconds; legal range 1..99.
- `WARN_SECONDS`, default 5: `warn` asserts while remaining time is 1..WARN_SECONDS; legal range 0..START_SECONDS.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  one-cycle pulse; loads START_SECONDS and runs.
- `stop`  in  1  one-cycle pulse; the player answered, so freeze the count.
- `pause`  in  1  level; holds the count while high.
- `tick_1s`  in  1  one-cycle pulse from the one-second timer.
- `timer_enable`  out  1  enable for the one-second timer; high only in RUNNING.
- `secs_tens`  out  4  BCD tens digit of the remaining seconds.
- `secs_ones`  out  4  BCD ones digit of the remaining seconds.
- `running`  out  1  high in RUNNING or PAUSED.
- `warn`  out  1  low-time indicator.
- `time_up`  out  1  one-cycle pulse when the count reaches 00.
- `expired`  out  1  level; high in EXPIRED.

## Operation
States: IDLE, RUNNING, PAUSED, HALTED, EXPIRED. All outputs are registered.
- Reset (`rst`=0 at an edge):
  - State goes to IDLE.
  - `secs_tens`/`secs_ones` load the BCD value of START_SECONDS.
  - `timer_enable`, `running`, `warn`, `time_up` and `expired` all go to 0.
- IDLE, HALTED, EXPIRED: `start` reloads START_SECONDS, clears `expired` and enters RUNNING. All other inputs are ignored.
- RUNNING, priority order (highest first):
  1. `start`: reload and stay in RUNNING (restart).
  2. `stop`: go to HALTED; the count freezes and is displayed as-is.
  3. `pause`=1: go to PAUSED; a coincident `tick_1s` is dropped.
  4. `tick_1s`: decrement the BCD count.
- BCD decrement:
  - If ones ≠ 0: ones−1.
  - Else: ones=9, tens−1.
  - Digits never hold values above 9.
- Terminal tick: a tick consumed with the count at 01 sets the count to 00, enters EXPIRED, and pulses `time_up` for exactly one cycle.
- PAUSED:
  - `tick_1s` is ignored.
  - `pause`=0 returns to RUNNING.
  - `stop` goes to HALTED.
  - `start` reloads and enters RUNNING.
- `warn` = (state RUNNING or PAUSED) and 1 ≤ count ≤ WARN_SECONDS. It is computed from the next-state count, so it is valid in the same cycle as the digits. It is never high at 00.
- `timer_enable` = (next state == RUNNING). The one-second chain therefore stops in the same cycle that PAUSED, HALTED or EXPIRED is entered.

## Timing
- Tick latency: `tick_1s` sampled high at edge N updates the digits at edge N, so the new value is visible during cycle N+1.
- `time_up` is high only during the cycle after the terminal edge. `expired` rises at that same edge and holds until `start` or reset.
- `start` at edge N:
  - Digits equal START_SECONDS and `running`=1 from cycle N+1.
  - A `tick_1s` coincident with `start` is ignored.
- Reset mid-round has priority over all inputs. No `time_up` is emitted on reset.
- Back-to-back ticks on consecutive cycles each decrement; no rate limiting is applied.
- START_SECONDS=1: the first tick expires the round.

## Test plan
- Full round: reset, `start`, then 30 ticks. Required response:
  - Digits step 30,29,…,10,09,…,01,00.
  - `warn` is high exactly at 05..01.
  - A single `time_up` pulse occurs after the 30th tick.
  - `expired`=1 and `timer_enable`=0.
- Tens borrow: count at 20 plus one tick gives 19. The sequence 10→09→08 holds `secs_tens`=0 with no invalid BCD.
- Pause:
  - At 12, raise `pause` with a coincident tick; the count stays 12.
  - 5 ticks while paused give no change and `timer_enable`=0.
  - Drop `pause`, then one tick gives 11.
- Stop versus tick: at 07, assert `stop` and `tick_1s` in the same cycle. The count holds 07 in HALTED, with no `time_up` and `warn`=0.
- Restart and reset:
  - `start` during RUNNING at 15 reloads 30.
  - In EXPIRED, `start` clears `expired` and reloads 30.
  - `rst`=0 at 03 gives IDLE, 30, and all flags 0 at the next edge.
